// File: rtl/dft_in_blkbuf.sv
// dft_in_blkbuf: ping-pong block buffer that collects one block of complex samples per bank
// and replays it contiguously to the DFT core while the other bank fills.
module dft_in_blkbuf #(
  parameter int DW      = 16,
  parameter int MAX_LEN = 1296,
  parameter int AW      = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          din_valid,
  output logic          din_ready,
  input  logic          din_sop,
  input  logic [DW-1:0] din_re,
  input  logic [DW-1:0] din_im,
  input  logic [AW-1:0] blk_len,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          dout_sop,
  output logic          dout_eop,
  output logic [DW-1:0] dout_re,
  output logic [DW-1:0] dout_im,
  output logic [AW-1:0] dout_len,
  output logic          err_sop,
  output logic          err_len
);
  localparam logic [AW-1:0] LMAX = AW'(MAX_LEN);
  typedef enum logic {IDLE, FILL} wst_t;
  wst_t            wst;
  logic            wbank, rbank, wbank_n;
  logic [1:0]      full, full_n;
  logic [AW-1:0]   waddr, wlen, raddr, w_addr, w_len;
  logic [AW-1:0]   blen [2];
  logic [2*DW-1:0] mem0 [MAX_LEN];
  logic [2*DW-1:0] mem1 [MAX_LEN];
  logic            in_beat, len_ok, wen, w_last, adv, issue, r_last;
  // A bank is released once its last word has been read into the output register,
  // so the writer can reuse it without a gap while that word is still being offered.
  always_comb begin
    in_beat = din_valid & din_ready;
    len_ok  = blk_len != '0 && blk_len <= LMAX;
    w_addr  = din_sop ? '0 : waddr;
    w_len   = din_sop ? blk_len : wlen;
    wen     = in_beat & (din_sop ? len_ok : wst == FILL);
    w_last  = wen & (w_addr == w_len - AW'(1));
    adv     = ~dout_valid | dout_ready;
    issue   = adv & full[rbank];
    r_last  = raddr == blen[rbank] - AW'(1);
    full_n  = full;
    if (w_last) full_n[wbank] = 1'b1;
    if (issue & r_last) full_n[rbank] = 1'b0;
    wbank_n = wbank ^ w_last;
  end
  always_ff @(posedge clk) begin
    if (wen & ~wbank) mem0[w_addr] <= {din_re, din_im};
    if (wen & wbank) mem1[w_addr] <= {din_re, din_im};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wst       <= IDLE;
      wbank     <= 1'b0;
      waddr     <= '0;
      wlen      <= '0;
      full      <= '0;
      blen[0]   <= '0;
      blen[1]   <= '0;
      din_ready <= 1'b1;
      err_sop   <= 1'b0;
      err_len   <= 1'b0;
    end else begin
      full      <= full_n;
      wbank     <= wbank_n;
      din_ready <= ~full_n[wbank_n];
      err_sop   <= in_beat & din_sop & len_ok & (wst == FILL);
      err_len   <= in_beat & din_sop & ~len_ok;
      if (w_last) blen[wbank] <= w_len;
      if (in_beat & din_sop) begin
        wst   <= len_ok & ~w_last ? FILL : IDLE;
        waddr <= AW'(1);
        wlen  <= blk_len;
      end else if (wen) begin
        wst   <= w_last ? IDLE : FILL;
        waddr <= waddr + AW'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rbank      <= 1'b0;
      raddr      <= '0;
      dout_valid <= 1'b0;
      dout_sop   <= 1'b0;
      dout_eop   <= 1'b0;
      dout_re    <= '0;
      dout_im    <= '0;
      dout_len   <= '0;
    end else if (issue) begin
      dout_valid         <= 1'b1;
      dout_sop           <= raddr == '0;
      dout_eop           <= r_last;
      dout_len           <= blen[rbank];
      {dout_re, dout_im} <= rbank ? mem1[raddr] : mem0[raddr];
      raddr              <= r_last ? '0 : raddr + AW'(1);
      rbank              <= rbank ^ r_last;
    end else if (adv) begin
      dout_valid <= 1'b0;
      dout_sop   <= 1'b0;
      dout_eop   <= 1'b0;
    end
  end
endmodule
